// File: rtl/conv_job_scheduler_if.sv
// Host config, engine job and output SRAM write signals of the
// convolution job scheduler, with scheduler (slave) and driver (master) views.
interface conv_job_scheduler_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10,
  parameter int DIM_WIDTH  = 6
);
  logic                  i_start;
  logic [ADDR_WIDTH-1:0] i_img_base;
  logic [ADDR_WIDTH-1:0] i_out_base;
  logic [DIM_WIDTH-1:0]  i_img_rows;
  logic [DIM_WIDTH-1:0]  i_img_cols;
  logic [2:0]            i_stride;
  logic                  o_conv_start;
  logic [ADDR_WIDTH-1:0] o_win1_addr;
  logic [ADDR_WIDTH-1:0] o_win2_addr;
  logic                  o_win2_valid;
  logic                  i_conv_done;
  logic [DATA_WIDTH-1:0] i_result1;
  logic [DATA_WIDTH-1:0] i_result2;
  logic                  o_wr_en;
  logic [ADDR_WIDTH-1:0] o_wr_addr;
  logic [DATA_WIDTH-1:0] o_wr_data;
  logic                  o_busy;
  logic                  o_done;
  logic                  o_err;

  modport slave (
    input  i_start, i_img_base, i_out_base,
    input  i_img_rows, i_img_cols, i_stride,
    input  i_conv_done, i_result1, i_result2,
    output o_conv_start, o_win1_addr, o_win2_addr,
    output o_win2_valid, o_wr_en, o_wr_addr,
    output o_wr_data, o_busy, o_done, o_err
  );

  modport master (
    output i_start, i_img_base, i_out_base,
    output i_img_rows, i_img_cols, i_stride,
    output i_conv_done, i_result1, i_result2,
    input  o_conv_start, o_win1_addr, o_win2_addr,
    input  o_win2_valid, o_wr_en, o_wr_addr,
    input  o_wr_data, o_busy, o_done, o_err
  );
endinterface

// File: rtl/conv_job_scheduler.sv
// Raster-order job sequencer: issues paired-window convolution jobs,
// waits for the engine and writes both results to the output SRAM.
module conv_job_scheduler #(
  parameter int KERNEL_SIZE = 3,
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 10,
  parameter int DIM_WIDTH   = 6
) (
  input logic                  i_clk,
  input logic                  i_rst,
  conv_job_scheduler_if.slave  bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_WR1   = 3'd3;
  localparam logic [2:0] S_WR2   = 3'd4;
  localparam logic [2:0] S_ADV   = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  localparam logic [DIM_WIDTH-1:0] K = DIM_WIDTH'(KERNEL_SIZE);

  logic [2:0]            state;
  logic [DIM_WIDTH-1:0]  ow;
  logic [DIM_WIDTH-1:0]  oh;
  logic [DIM_WIDTH-1:0]  orow;
  logic [DIM_WIDTH:0]    oc;
  logic [2:0]            stride;
  logic [ADDR_WIDTH-1:0] row_base;
  logic [ADDR_WIDTH-1:0] col_off;
  logic [ADDR_WIDTH-1:0] row_step;
  logic [ADDR_WIDTH-1:0] out_ptr;
  logic [DATA_WIDTH-1:0] res1;
  logic [DATA_WIDTH-1:0] res2;
  logic                  err;

  logic                  cfg_bad;
  logic [DIM_WIDTH-1:0]  div_s;
  logic [DIM_WIDTH-1:0]  ow_calc;
  logic [DIM_WIDTH-1:0]  oh_calc;
  logic [DIM_WIDTH+2:0]  step_prod;
  logic [ADDR_WIDTH-1:0] win1;
  logic [ADDR_WIDTH-1:0] win2;
  logic                  win2_valid;
  logic [DIM_WIDTH:0]    oc_next;

  assign cfg_bad = (bus.i_stride == 3'd0)
                 || (bus.i_img_rows < K)
                 || (bus.i_img_cols < K);

  // Divisor forced non-zero; a zero stride is rejected by cfg_bad anyway
  assign div_s = DIM_WIDTH'((bus.i_stride == 3'd0) ? 3'd1 : bus.i_stride);
  assign ow_calc = (bus.i_img_cols - K) / div_s + 1'b1;
  assign oh_calc = (bus.i_img_rows - K) / div_s + 1'b1;
  assign step_prod = {{DIM_WIDTH{1'b0}}, bus.i_stride}
                   * {3'b000, bus.i_img_cols};

  assign win1 = row_base + col_off;
  assign win2 = win1 + ADDR_WIDTH'(stride);
  assign win2_valid = (oc + 1'b1) < {1'b0, ow};
  assign oc_next = oc + 2'd2;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= S_IDLE;
      ow       <= '0;
      oh       <= '0;
      orow     <= '0;
      oc       <= '0;
      stride   <= '0;
      row_base <= '0;
      col_off  <= '0;
      row_step <= '0;
      out_ptr  <= '0;
      res1     <= '0;
      res2     <= '0;
      err      <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (bus.i_start) begin
            ow       <= ow_calc;
            oh       <= oh_calc;
            orow     <= '0;
            oc       <= '0;
            stride   <= bus.i_stride;
            row_base <= bus.i_img_base;
            col_off  <= '0;
            row_step <= ADDR_WIDTH'(step_prod);
            out_ptr  <= bus.i_out_base;
            err      <= cfg_bad;
            state    <= cfg_bad ? S_DONE : S_ISSUE;
          end
        end
        S_ISSUE: state <= S_WAIT;
        S_WAIT: begin
          if (bus.i_conv_done) begin
            res1  <= bus.i_result1;
            res2  <= bus.i_result2;
            state <= S_WR1;
          end
        end
        S_WR1: begin
          out_ptr <= out_ptr + 1'b1;
          state   <= win2_valid ? S_WR2 : S_ADV;
        end
        S_WR2: begin
          out_ptr <= out_ptr + 1'b1;
          state   <= S_ADV;
        end
        S_ADV: begin
          // Row wrap keeps row_base as a running sum instead of orow*S*C
          if (oc_next >= {1'b0, ow}) begin
            oc       <= '0;
            col_off  <= '0;
            orow     <= orow + 1'b1;
            row_base <= row_base + row_step;
            state    <= (orow + 1'b1 == oh) ? S_DONE : S_ISSUE;
          end else begin
            oc      <= oc_next;
            col_off <= col_off + ADDR_WIDTH'({stride, 1'b0});
            state   <= S_ISSUE;
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.o_conv_start = (state == S_ISSUE);
  assign bus.o_win1_addr  = win1;
  assign bus.o_win2_addr  = win2;
  assign bus.o_win2_valid = win2_valid;
  assign bus.o_wr_en      = (state == S_WR1) || (state == S_WR2);
  assign bus.o_wr_addr    = out_ptr;
  assign bus.o_wr_data    = (state == S_WR1) ? res1
                          : (state == S_WR2) ? res2
                          : '0;
  assign bus.o_busy       = (state != S_IDLE);
  assign bus.o_done       = (state == S_DONE);
  assign bus.o_err        = (state == S_DONE) && err;

endmodule

// File: tb/tb_conv_job_scheduler.sv
// Bench for conv_job_scheduler: table of feature-map configs checked
// through a job/write scoreboard, plus reset and stray-pulse sequences.
module tb_conv_job_scheduler;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  conv_job_scheduler_if #(
    .DATA_WIDTH(8), .ADDR_WIDTH(10), .DIM_WIDTH(6)
  ) bus ();

  conv_job_scheduler dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  typedef struct {
    int rows; int cols; int stride;
    int img;  int outb;
    int jobs; int wrs;  int err;
    int last_win1; int last_wr;
  } vec_t;

  typedef struct { int w1; int w2; int v; } job_t;

  vec_t vecs[7];
  job_t job_q[$];
  int   addr_q[$];
  int   data_q[$];

  int checks = 0;
  int errors = 0;
  int lat = 1;
  bit inject = 0;
  int gen = 0;
  int job_cnt = 0;
  int wr_cnt = 0;
  int last_win1 = 0;
  int last_wr = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_model(vec_t v);
    int ow, oh, w1;
    if (v.stride == 0 || v.rows < 3 || v.cols < 3) return;
    ow = (v.cols - 3) / v.stride + 1;
    oh = (v.rows - 3) / v.stride + 1;
    for (int r = 0; r < oh; r++)
      for (int c = 0; c < ow; c += 2) begin
        w1 = (v.img + r * v.stride * v.cols + c * v.stride) % 1024;
        job_q.push_back('{w1, (w1 + v.stride) % 1024,
                          (c + 1 < ow) ? 1 : 0});
      end
    for (int k = 0; k < oh * ow; k++)
      addr_q.push_back((v.outb + k) % 1024);
  endtask

  task automatic drive_cfg(vec_t v);
    bus.i_img_rows = 6'(v.rows);
    bus.i_img_cols = 6'(v.cols);
    bus.i_stride   = 3'(v.stride);
    bus.i_img_base = 10'(v.img);
    bus.i_out_base = 10'(v.outb);
  endtask

  task automatic scramble_cfg();
    bus.i_img_rows = 6'($urandom_range(0, 63));
    bus.i_img_cols = 6'($urandom_range(0, 63));
    bus.i_stride   = 3'($urandom_range(0, 7));
    bus.i_img_base = 10'($urandom_range(0, 1023));
    bus.i_out_base = 10'($urandom_range(0, 1023));
  endtask

  task automatic check_idle_outputs(string tag);
    check({tag, "_addr"},
          {2'b0, bus.o_win1_addr, bus.o_win2_addr, bus.o_wr_addr}, 0);
    check({tag, "_ctl"},
          {18'b0, bus.o_conv_start, bus.o_win2_valid, bus.o_wr_en,
           bus.o_wr_data, bus.o_busy, bus.o_done, bus.o_err}, 0);
  endtask

  task automatic run_cfg(vec_t v, int l, bit inj, bit extra);
    int cyc;
    lat = l;
    inject = inj;
    job_cnt = 0;
    wr_cnt = 0;
    push_model(v);
    @(negedge clk);
    drive_cfg(v);
    bus.i_start = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
    scramble_cfg();
    cyc = 0;
    while (!bus.o_done && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      bus.i_start = (extra && cyc == 10);
    end
    bus.i_start = 1'b0;
    check("done_seen", bus.o_done, 1);
    check("done_busy", bus.o_busy, 1);
    check("done_err", bus.o_err, v.err);
    check("job_count", job_cnt, v.jobs);
    check("wr_count", wr_cnt, v.wrs);
    check("job_q_left", job_q.size(), 0);
    check("addr_q_left", addr_q.size(), 0);
    check("data_q_left", data_q.size(), 0);
    if (v.jobs > 0) check("last_win1", last_win1, v.last_win1);
    if (v.wrs > 0) check("last_wr", last_wr, v.last_wr);
    // start in the DONE cycle must not relaunch
    bus.i_start = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
    check("post_done_busy", bus.o_busy, 0);
    check("post_done_pulse", bus.o_done, 0);
    repeat (3) @(negedge clk);
    check("post_done_idle", {bus.o_busy, bus.o_conv_start}, 0);
    check("post_done_jobs", job_cnt, v.jobs);
  endtask

  // Engine model: checks each issued job, answers after lat cycles
  initial begin
    job_t e;
    int g, r1, r2;
    bit held;
    logic [9:0] w1, w2;
    bus.i_conv_done = 1'b0;
    bus.i_result1 = '0;
    bus.i_result2 = '0;
    forever begin
      @(negedge clk);
      if (bus.o_conv_start) begin
        job_cnt++;
        last_win1 = bus.o_win1_addr;
        w1 = bus.o_win1_addr;
        w2 = bus.o_win2_addr;
        if (job_q.size() == 0) begin
          check("job_unexpected", 1, 0);
          e = '{0, 0, 0};
        end else begin
          e = job_q.pop_front();
          check("win1_addr", bus.o_win1_addr, e.w1);
          check("win2_addr", bus.o_win2_addr, e.w2);
          check("win2_valid", bus.o_win2_valid, e.v);
        end
        g = gen;
        held = 1'b1;
        repeat (lat) begin
          @(negedge clk);
          if (bus.o_win1_addr !== w1 || bus.o_win2_addr !== w2)
            held = 1'b0;
        end
        if (g == gen) begin
          check("addr_held", held, 1);
          r1 = $urandom_range(0, 255);
          r2 = $urandom_range(0, 255);
          bus.i_result1 = 8'(r1);
          bus.i_result2 = 8'(r2);
          bus.i_conv_done = 1'b1;
          data_q.push_back(r1);
          if (e.v != 0) data_q.push_back(r2);
          if (inject) begin
            @(negedge clk);
            bus.i_result1 = 8'(r1 ^ 8'h5a);
            bus.i_result2 = 8'(r2 ^ 8'ha5);
          end
          @(negedge clk);
          bus.i_conv_done = 1'b0;
          bus.i_result1 = '0;
          bus.i_result2 = '0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (bus.o_wr_en) begin
      wr_cnt++;
      last_wr = bus.o_wr_addr;
      if (addr_q.size() == 0 || data_q.size() == 0)
        check("wr_unexpected", 1, 0);
      else begin
        check("wr_addr", bus.o_wr_addr, addr_q.pop_front());
        check("wr_data", bus.o_wr_data, data_q.pop_front());
      end
    end
  end

  initial begin
    int cyc;
    //          R   C  S  img  out jobs  wr err lastw1 lastwr
    vecs[0] = '{5,  5, 1, 0,    100, 6,   9, 0, 12,  108};
    vecs[1] = '{5,  5, 2, 0,    100, 2,   4, 0, 10,  103};
    vecs[2] = '{5,  5, 0, 0,    100, 0,   0, 1, 0,   0};
    vecs[3] = '{5,  2, 1, 0,    100, 0,   0, 1, 0,   0};
    vecs[4] = '{7,  9, 2, 50,   900, 6,  12, 0, 90,  911};
    vecs[5] = '{5,  5, 1, 1000, 1020, 6,  9, 0, 1012, 4};
    vecs[6] = '{28, 28, 1, 0,   200, 338, 676, 0, 724, 875};

    bus.i_start = 1'b0;
    drive_cfg(vecs[0]);
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++)
      run_cfg(vecs[i], 1 + i % 3, 1'b0, 1'b0);

    // slow engine, stray start mid-run, stray done during WR1
    run_cfg(vecs[0], 7, 1'b1, 1'b1);

    // reset while the engine is still working
    lat = 20;
    inject = 0;
    job_cnt = 0;
    push_model(vecs[0]);
    @(negedge clk);
    drive_cfg(vecs[0]);
    bus.i_start = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
    cyc = 0;
    while (job_cnt == 0 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("rst_job_seen", job_cnt, 1);
    repeat (3) @(negedge clk);
    check("rst_wait_state", {bus.o_busy, bus.o_conv_start, bus.o_wr_en},
          3'b100);
    rst = 1'b1;
    gen++;
    @(negedge clk);
    check_idle_outputs("rst_mid");
    rst = 1'b0;
    job_q.delete();
    addr_q.delete();
    data_q.delete();
    repeat (30) @(negedge clk);
    check("rst_quiet", {bus.o_busy, bus.o_wr_en}, 0);
    run_cfg(vecs[0], 1, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
